// File: rtl/sw_dma_writer_pkg.sv
// Shared definitions for the switch-sampling write DMA: CSR word offsets,
// CTRL/STATUS bit positions and the engine state encoding.
package sw_dma_writer_pkg;

    // CSR word offsets on the slave port
    localparam logic [1:0] CSR_DST    = 2'd0;
    localparam logic [1:0] CSR_COUNT  = 2'd1;
    localparam logic [1:0] CSR_CTRL   = 2'd2;
    localparam logic [1:0] CSR_STATUS = 2'd3;

    // CTRL bits: go and abort are strobes, irq_en is stored
    localparam int CTRL_GO     = 0;
    localparam int CTRL_ABORT  = 1;
    localparam int CTRL_IRQ_EN = 2;

    // STATUS bits: remaining word count sits in the upper half-word
    localparam int STATUS_BUSY    = 0;
    localparam int STATUS_DONE    = 1;
    localparam int STATUS_REM_LSB = 16;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

endpackage

// File: rtl/sw_dma_writer_csr.sv
// CSR slave for the write DMA: DST/COUNT/CTRL storage, STATUS readback and
// decode of the self-clearing go/abort strobes and the STATUS done-clear.
module sw_dma_writer_csr
    import sw_dma_writer_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    input  logic              busy,
    input  logic              done,
    input  logic [CNT_W-1:0]  remaining,
    output logic [ADDR_W-1:0] dst,
    output logic [CNT_W-1:0]  count,
    output logic              irq_en,
    output logic              go,
    output logic              abort,
    output logic              status_clr
);

    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              irq_en_q, irq_en_d;
    logic [31:0]       rdata_q, rdata_d;

    // Strobes act on the same edge the write is sampled, so they never read back
    assign go         = avs_write && (avs_address == CSR_CTRL) && avs_writedata[CTRL_GO];
    assign abort      = avs_write && (avs_address == CSR_CTRL) && avs_writedata[CTRL_ABORT];
    assign status_clr = avs_write && (avs_address == CSR_STATUS);

    assign dst          = dst_q;
    assign count        = count_q;
    assign irq_en       = irq_en_q;
    assign avs_readdata = rdata_q;

    // Register updates (DST/COUNT frozen while busy) and the readLatency=1 read mux
    always_comb begin
        dst_d    = dst_q;
        count_d  = count_q;
        irq_en_d = irq_en_q;
        rdata_d  = '0;
        if (avs_write) begin
            case (avs_address)
                CSR_DST:   if (!busy) dst_d = {avs_writedata[ADDR_W-1:2], 2'b00};
                CSR_COUNT: if (!busy) count_d = avs_writedata[CNT_W-1:0];
                CSR_CTRL:  irq_en_d = avs_writedata[CTRL_IRQ_EN];
                default:   ;
            endcase
        end
        if (avs_read) begin
            case (avs_address)
                CSR_DST:   rdata_d = 32'(dst_q);
                CSR_COUNT: rdata_d = 32'(count_q);
                CSR_CTRL:  rdata_d[CTRL_IRQ_EN] = irq_en_q;
                default: begin
                    rdata_d[STATUS_BUSY] = busy;
                    rdata_d[STATUS_DONE] = done;
                    rdata_d[31:STATUS_REM_LSB] = 16'(remaining);
                end
            endcase
        end
    end

    // CSR storage and registered read data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dst_q    <= '0;
            count_q  <= '0;
            irq_en_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            dst_q    <= dst_d;
            count_q  <= count_d;
            irq_en_q <= irq_en_d;
            rdata_q  <= rdata_d;
        end
    end

endmodule

// File: rtl/sw_dma_writer.sv
// Write DMA: streams {seq, sample} words to consecutive word addresses on an
// Avalon-MM master after the HPS programs DST/COUNT and writes go.
module sw_dma_writer
    import sw_dma_writer_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int CNT_W    = 16,
    parameter int SAMPLE_W = 10
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          avs_address,
    input  logic                avs_read,
    input  logic                avs_write,
    input  logic [31:0]         avs_writedata,
    output logic [31:0]         avs_readdata,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_write,
    output logic [31:0]         avm_writedata,
    output logic [3:0]          avm_byteenable,
    input  logic                avm_waitrequest,
    input  logic [SAMPLE_W-1:0] sample,
    output logic                irq,
    output logic                dbg_state
);

    localparam int SEQ_W = 32 - SAMPLE_W;

    // Handshake: a beat is presented while avm_write=1 with address/data held
    // constant; it is accepted on an edge where avm_waitrequest=0, and only then
    // may the next beat (or the drop of avm_write) appear.

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    rem_q, rem_d, rem_dec;
    logic [SEQ_W-1:0]    seq_q, seq_d;
    logic [SAMPLE_W-1:0] samp_q, samp_d;
    logic                done_q, done_d;
    logic                abort_pend_q, abort_pend_d;
    logic                write_q, write_d;

    logic [ADDR_W-1:0]   dst;
    logic [CNT_W-1:0]    count;
    logic                irq_en, go, abort, status_clr, busy, accept;

    assign busy           = (state_q == XFER);
    assign accept         = write_q && !avm_waitrequest;
    assign rem_dec        = rem_q - CNT_W'(1);
    assign avm_write      = write_q;
    assign avm_address    = addr_q;
    assign avm_writedata  = {seq_q, samp_q};
    assign avm_byteenable = 4'hF;
    assign irq            = done_q && irq_en;
    assign dbg_state      = busy;

    sw_dma_writer_csr #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_csr (
        .clk           (clk),
        .reset_n       (reset_n),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .busy          (busy),
        .done          (done_q),
        .remaining     (rem_q),
        .dst           (dst),
        .count         (count),
        .irq_en        (irq_en),
        .go            (go),
        .abort         (abort),
        .status_clr    (status_clr)
    );

    // Next-state logic: start on go, advance on every accepted beat, stop on
    // the last beat or the first acceptance after an abort request
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rem_d        = rem_q;
        seq_d        = seq_q;
        samp_d       = samp_q;
        done_d       = done_q;
        abort_pend_d = abort_pend_q;
        write_d      = write_q;
        case (state_q)
            IDLE: begin
                abort_pend_d = 1'b0;
                if (status_clr) done_d = 1'b0;
                if (go) begin
                    if (count != '0) begin
                        state_d = XFER;
                        write_d = 1'b1;
                        addr_d  = dst;
                        rem_d   = count;
                        seq_d   = '0;
                        samp_d  = sample;
                        done_d  = 1'b0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            XFER: begin
                if (abort) abort_pend_d = 1'b1;
                if (accept) begin
                    addr_d = addr_q + ADDR_W'(4);
                    rem_d  = rem_dec;
                    seq_d  = seq_q + SEQ_W'(1);
                    samp_d = sample;
                    if (rem_dec == '0 || abort_pend_q || abort) begin
                        state_d      = IDLE;
                        write_d      = 1'b0;
                        done_d       = 1'b1;
                        abort_pend_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and datapath registers; reset drops avm_write immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            rem_q        <= '0;
            seq_q        <= '0;
            samp_q       <= '0;
            done_q       <= 1'b0;
            abort_pend_q <= 1'b0;
            write_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rem_q        <= rem_d;
            seq_q        <= seq_d;
            samp_q       <= samp_d;
            done_q       <= done_d;
            abort_pend_q <= abort_pend_d;
            write_q      <= write_d;
        end
    end

endmodule

// File: tb/tb_sw_dma_writer.sv
// Bench for sw_dma_writer: random samples and waitrequest, accepted beats
// collected at the bus and compared against addresses/sequence numbers
// derived from DST/COUNT, with samples taken from the value driven at the
// edge each beat was presented.
module tb_sw_dma_writer;

    localparam int ADDR_W   = 32;
    localparam int CNT_W    = 16;
    localparam int SAMPLE_W = 10;
    localparam int SEQ_W    = 32 - SAMPLE_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]          avs_address = '0;
    logic                avs_read = 1'b0;
    logic                avs_write = 1'b0;
    logic [31:0]         avs_writedata = '0;
    logic [31:0]         avs_readdata;
    logic [ADDR_W-1:0]   avm_address;
    logic                avm_write;
    logic [31:0]         avm_writedata;
    logic [3:0]          avm_byteenable;
    logic                avm_waitrequest = 1'b0;
    logic [SAMPLE_W-1:0] sample = '0;
    logic                irq;
    logic                dbg_state;

    sw_dma_writer #(
        .ADDR_W   (ADDR_W),
        .CNT_W    (CNT_W),
        .SAMPLE_W (SAMPLE_W)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .avs_address     (avs_address),
        .avs_read        (avs_read),
        .avs_write       (avs_write),
        .avs_writedata   (avs_writedata),
        .avs_readdata    (avs_readdata),
        .avm_address     (avm_address),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_byteenable  (avm_byteenable),
        .avm_waitrequest (avm_waitrequest),
        .sample          (sample),
        .irq             (irq),
        .dbg_state       (dbg_state)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [31:0]         acc_addr_q[$];
    logic [31:0]         acc_data_q[$];
    logic [SAMPLE_W-1:0] exp_q[$];        // sample expected in each accepted beat
    logic [SAMPLE_W-1:0] pres_sample = '0;
    bit                  m_busy = 1'b0;   // bench's own notion of a running transfer
    bit                  stall_prev = 1'b0;
    logic [31:0]         prev_addr = '0;
    logic [31:0]         prev_data = '0;

    always @(posedge clk) begin
        if (reset_n) begin
            if (stall_prev) begin
                check("stall_addr", avm_address, prev_addr);
                check("stall_data", avm_writedata, prev_data);
            end
            if (avm_write && !avm_waitrequest) begin
                acc_addr_q.push_back(avm_address);
                acc_data_q.push_back(avm_writedata);
                exp_q.push_back(pres_sample);
                pres_sample = sample;
            end
            if (avs_write && avs_address == 2'd2 && avs_writedata[0] && !m_busy)
                pres_sample = sample;
            stall_prev = avm_write && avm_waitrequest;
            prev_addr  = avm_address;
            prev_data  = avm_writedata;
        end else begin
            stall_prev = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        @(posedge clk); #1;
        avs_write     = 1'b0;
    endtask

    task automatic csr_read(input logic [1:0] a, output logic [31:0] d);
        avs_address = a;
        avs_read    = 1'b1;
        @(posedge clk); #1;
        avs_read    = 1'b0;
        d = avs_readdata;
    endtask

    task automatic clear_sb();
        acc_addr_q.delete();
        acc_data_q.delete();
        exp_q.delete();
    endtask

    // mode 0: no waitrequest, 1: 5-cycle stall on beat 1, 2: random waitrequest
    task automatic run_xfer(input logic [31:0] dst, input int cnt, input int mode,
                            input int abort_at, input bit ien);
        int          exp_beats;
        int          cyc;
        int          stall_n;
        bit          aborted;
        bit          prev_wr;
        logic [31:0] rd;
        logic [31:0] base;
        clear_sb();
        base = dst & 32'hFFFF_FFFC;
        csr_write(2'd0, dst);
        csr_write(2'd1, 32'(cnt));
        csr_write(2'd2, {29'd0, ien, 1'b0, 1'b1});
        m_busy = 1'b1;
        check("go_avm_write", {31'd0, avm_write}, 32'd1);
        check("go_dbg_state", {31'd0, dbg_state}, 32'd1);
        exp_beats = cnt;
        cyc = 0; stall_n = 0; aborted = 1'b0; prev_wr = 1'b0;
        while (avm_write && cyc < 3000) begin
            sample = SAMPLE_W'($urandom);
            case (mode)
                1: begin
                    if (acc_addr_q.size() == 1 && stall_n < 5) begin
                        avm_waitrequest = 1'b1;
                        stall_n++;
                    end else begin
                        avm_waitrequest = 1'b0;
                    end
                end
                2:       avm_waitrequest = ($urandom_range(0, 2) == 0);
                default: avm_waitrequest = 1'b0;
            endcase
            if (abort_at >= 0 && !aborted && acc_addr_q.size() >= abort_at) begin
                avs_address   = 2'd2;
                avs_writedata = {29'd0, ien, 2'b10};
                avs_write     = 1'b1;
                aborted       = 1'b1;
                exp_beats     = (acc_addr_q.size() + 1 < cnt) ? acc_addr_q.size() + 1 : cnt;
            end
            prev_wr = avm_waitrequest;
            @(posedge clk); #1;
            avs_write = 1'b0;
            cyc++;
        end
        if (cyc >= 3000) check("xfer_timeout", 32'(cyc), 32'd0);
        // avm_write must fall right after an accepting edge, with done/irq already set
        check("end_after_accept", {31'd0, prev_wr}, 32'd0);
        check("end_irq", {31'd0, irq}, {31'd0, ien});
        avm_waitrequest = 1'b0;
        m_busy = 1'b0;
        check("n_beats", 32'(acc_addr_q.size()), 32'(exp_beats));
        for (int i = 0; i < acc_addr_q.size(); i++) begin
            check($sformatf("beat%0d_addr", i), acc_addr_q[i], base + 32'(4 * i));
            check($sformatf("beat%0d_data", i), acc_data_q[i], {SEQ_W'(i), exp_q[i]});
        end
        csr_read(2'd3, rd);
        check("end_status", rd, {16'(cnt - exp_beats), 14'd0, 1'b1, 1'b0});
        csr_write(2'd3, 32'd0);
        check("status_clr_irq", {31'd0, irq}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] rd;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // reset state
        check("rst_avm_write", {31'd0, avm_write}, 32'd0);
        check("rst_avm_address", avm_address, 32'd0);
        check("rst_avm_writedata", avm_writedata, 32'd0);
        check("rst_readdata", avs_readdata, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("byteenable", {28'd0, avm_byteenable}, 32'hF);
        for (int a = 0; a < 4; a++) begin
            csr_read(2'(a), rd);
            check($sformatf("rst_csr%0d", a), rd, 32'd0);
        end

        // DST alignment and write-then-read
        csr_write(2'd0, 32'h0000_1003);
        csr_read(2'd0, rd);
        check("dst_align", rd, 32'h0000_1000);

        // basic 4-word transfer
        run_xfer(32'h0000_1003, 4, 0, -1, 1'b1);

        // stall on beat 1
        run_xfer(32'h0000_4000, 3, 1, -1, 1'b0);

        // zero count
        csr_write(2'd1, 32'd0);
        csr_write(2'd2, 32'h5);
        check("zero_irq", {31'd0, irq}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("zero_no_write", {31'd0, avm_write}, 32'd0);
            @(posedge clk); #1;
        end
        csr_read(2'd3, rd);
        check("zero_status", rd, 32'h0000_0002);
        csr_write(2'd3, 32'd0);
        check("zero_clr_irq", {31'd0, irq}, 32'd0);
        csr_read(2'd3, rd);
        check("zero_clr_status", rd, 32'd0);

        // abort under random waitrequest
        run_xfer(32'h0010_0000, 100, 2, 10, 1'b1);

        // address wrap
        run_xfer(32'hFFFF_FFF8, 3, 0, -1, 1'b0);

        // random transfers
        for (int t = 0; t < 3; t++)
            run_xfer($urandom, $urandom_range(1, 20), 2, -1, 1'($urandom_range(0, 1)));

        // reset in the middle of a stalled transfer
        avm_waitrequest = 1'b1;
        csr_write(2'd0, 32'h0000_2000);
        csr_write(2'd1, 32'd8);
        csr_write(2'd2, 32'h1);
        m_busy = 1'b1;
        check("rstx_avm_write", {31'd0, avm_write}, 32'd1);
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b0;
        #1 check("rstx_async_drop", {31'd0, avm_write}, 32'd0);
        m_busy = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        avm_waitrequest = 1'b0;
        for (int a = 0; a < 4; a++) begin
            csr_read(2'(a), rd);
            check($sformatf("rstx_csr%0d", a), rd, 32'd0);
        end
        run_xfer(32'h0000_3000, 5, 2, -1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // global watchdog
    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=0x%08h exp=0x%08h", n_checks, 0);
        $fatal(1, "simulation did not finish");
    end

endmodule
